// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT front-end framing logic.
package fft_pkg;

    localparam int unsigned FRAME_LEN_DEF = 512;
    localparam int unsigned DATA_W_DEF    = 16;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_FLUSH} seq_state_t;

    // Width of fftpts and the index counter: must be able to hold FRAME_LEN itself.
    function automatic int unsigned idx_w(input int unsigned frame_len);
        return $clog2(frame_len) + 1;
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Avalon-ST sink bundle toward the FFT core, plus its per-frame sideband.
interface fft_frame_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 10
) ();

    logic              fft_sink_ready;
    logic              fft_sink_valid;
    logic              fft_sink_sop;
    logic              fft_sink_eop;
    logic [DATA_W-1:0] fft_sink_real;
    logic [DATA_W-1:0] fft_sink_imag;
    logic [1:0]        fft_sink_error;
    logic              fft_inverse;
    logic [IDX_W-1:0]  fft_fftpts;

    modport master (
        input  fft_sink_ready,
        output fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag,
        output fft_sink_error, fft_inverse, fft_fftpts
    );

    modport slave (
        output fft_sink_ready,
        input  fft_sink_valid, fft_sink_sop, fft_sink_eop, fft_sink_real, fft_sink_imag,
        input  fft_sink_error, fft_inverse, fft_fftpts
    );

endinterface

// File: rtl/avst_out_reg.sv
// Single-beat Avalon-ST output register: holds data/sop/eop until the sink takes it.
module avst_out_reg #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              sop,
    output logic              eop,
    output logic              free
);

    // Load wins over drain so a transfer and a new load in one cycle keep valid high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            sop   <= 1'b0;
            eop   <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= in_data;
            sop   <= in_sop;
            eop   <= in_eop;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

    assign free = !valid || ready;

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames a free-running sample stream into FRAME_LEN-point blocks for the FFT sink.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned IDX_W     = idx_w(FRAME_LEN)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  inverse_req,
    input  logic                  sample_valid,
    input  logic [DATA_W-1:0]     sample_data,
    output logic                  sample_ready,
    fft_frame_sequencer_if.master bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic [15:0]           drop_cnt
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FRAME_LEN - 1);

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic              inverse_q;
    logic              beat_valid, beat_sop, beat_eop, reg_free;
    logic [DATA_W-1:0] beat_data;
    logic              idx_zero, accept, xfer, bp_drop;

    assign idx_zero = (idx_q == '0);
    // A new frame may only start while streaming; once stopping, only the open frame
    // is completed so a truncated frame never reaches the FFT.
    assign sample_ready = (state_q != SEQ_IDLE) && reg_free &&
                          (!idx_zero || (enable && state_q == SEQ_RUN));
    assign accept  = sample_valid && sample_ready;
    assign xfer    = beat_valid && bus.fft_sink_ready;
    // Only samples lost to sink back-pressure count; those refused at a stop boundary
    // are ignored just like samples in IDLE.
    assign bp_drop = sample_valid && (state_q != SEQ_IDLE) && !reg_free;

    avst_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (accept),
        .in_data (sample_data),
        .in_sop  (idx_zero),
        .in_eop  (idx_q == LastIdx),
        .ready   (bus.fft_sink_ready),
        .valid   (beat_valid),
        .data    (beat_data),
        .sop     (beat_sop),
        .eop     (beat_eop),
        .free    (reg_free)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEQ_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: stop at frame boundaries, finish an open frame before idling.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (enable) state_d = SEQ_RUN;
            end
            SEQ_RUN: begin
                if (!enable) begin
                    if (!idx_zero)     state_d = SEQ_FLUSH;
                    else if (reg_free) state_d = SEQ_IDLE;
                end
            end
            SEQ_FLUSH: begin
                if (xfer && beat_eop)         state_d = SEQ_IDLE;
                else if (enable && !idx_zero) state_d = SEQ_RUN;
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // Frame index, per-frame direction latch and eop-transfer pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q      <= '0;
            inverse_q  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= xfer && beat_eop;
            if (accept) begin
                idx_q <= (idx_q == LastIdx) ? '0 : idx_q + IDX_W'(1);
                if (idx_zero) inverse_q <= inverse_req;
            end
        end
    end

    // Sticky overrun flag and saturating drop counter; cleared by reset only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (bp_drop) begin
            overrun <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign busy               = (state_q != SEQ_IDLE);
    assign bus.fft_sink_valid = beat_valid;
    assign bus.fft_sink_sop   = beat_sop;
    assign bus.fft_sink_eop   = beat_eop;
    assign bus.fft_sink_real  = beat_data;
    assign bus.fft_sink_imag  = '0;
    assign bus.fft_sink_error = '0;
    assign bus.fft_inverse    = inverse_q;
    assign bus.fft_fftpts     = IDX_W'(FRAME_LEN);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: table vectors, directed corner cases, random traffic
// checked against a transaction-level model (queue of accepted samples).
module tb_fft_frame_sequencer;
    import fft_pkg::*;

    localparam int unsigned N  = 512;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 10;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          inverse_req = 1'b0;
    logic          sample_valid = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          sample_ready, busy, frame_done, overrun;
    logic [15:0]   drop_cnt;

    fft_frame_sequencer_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

    fft_frame_sequencer #(
        .DATA_W    (DW),
        .FRAME_LEN (N),
        .IDX_W     (IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .inverse_req  (inverse_req),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .bus          (bus),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int fail_prints = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            if (fail_prints < 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
            fail_prints++;
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] data;
        bit            sop;
        bit            eop;
    } beat_t;

    beat_t mq[$];     // accepted samples not yet taken by the sink
    int    m_mode;    // 0 stopped, 1 streaming, 2 finishing the open frame
    int    m_pos;     // samples accepted so far in the open frame
    int    m_total;   // samples accepted since reset
    int    m_drops;
    bit    m_inv, m_done, m_ovr, m_acc;

    function automatic void m_reset();
        mq.delete();
        m_mode = 0; m_pos = 0; m_total = 0; m_drops = 0;
        m_inv = 0; m_done = 0; m_ovr = 0; m_acc = 0;
    endfunction

    function automatic bit m_ready();
        bit room = (mq.size() == 0) || bus.fft_sink_ready;
        bit may_take = (m_pos != 0) || (enable && m_mode == 1);
        return (m_mode != 0) && room && may_take;
    endfunction

    function automatic void m_step();
        bit rdy   = m_ready();
        bit full  = (mq.size() != 0);
        bit xfer  = full && bus.fft_sink_ready;
        bit eop_x = xfer && mq[0].eop;
        int pos0  = m_pos;
        int mode0 = m_mode;
        if (sample_valid && mode0 != 0 && full && !bus.fft_sink_ready) begin
            m_ovr = 1;
            if (m_drops < 65535) m_drops++;
        end
        m_done = eop_x;
        if (xfer) void'(mq.pop_front());
        m_acc = sample_valid && rdy;
        if (m_acc) begin
            mq.push_back('{data: sample_data, sop: (pos0 == 0), eop: (pos0 == N - 1)});
            if (pos0 == 0) m_inv = inverse_req;
            m_pos = (pos0 + 1) % N;
            m_total++;
        end
        case (mode0)
            0: if (enable) m_mode = 1;
            1: if (!enable) begin
                   if (pos0 != 0) m_mode = 2;
                   else if (!full || bus.fft_sink_ready) m_mode = 0;
               end
            2: if (eop_x) m_mode = 0;
               else if (enable && pos0 != 0) m_mode = 1;
            default: m_mode = 0;
        endcase
    endfunction

    // ---------------- cycle helpers ----------------
    bit            x_now, x_sop, x_eop, x_inv, done_now;
    logic [DW-1:0] x_data;
    logic [DW-1:0] ramp;

    task automatic check_model();
        check("sample_ready", sample_ready, m_ready());
        check("valid", bus.fft_sink_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            check("data", bus.fft_sink_real, mq[0].data);
            check("sop", bus.fft_sink_sop, mq[0].sop);
            check("eop", bus.fft_sink_eop, mq[0].eop);
        end
        check("inverse", bus.fft_inverse, m_inv);
        check("busy", busy, m_mode != 0);
        check("frame_done", frame_done, m_done);
        check("overrun", overrun, m_ovr);
        check("drop_cnt", drop_cnt, m_drops);
    endtask

    // Inputs are set at the falling edge; outputs are sampled 1 ns later.
    task automatic cycle(input bit chk);
        #1;
        if (chk) check_model();
        x_now    = bus.fft_sink_valid && bus.fft_sink_ready;
        x_sop    = bus.fft_sink_sop;
        x_eop    = bus.fft_sink_eop;
        x_inv    = bus.fft_inverse;
        x_data   = bus.fft_sink_real;
        done_now = frame_done;
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check("rst_sample_ready", sample_ready, 0);
        check("rst_valid", bus.fft_sink_valid, 0);
        check("rst_sop", bus.fft_sink_sop, 0);
        check("rst_eop", bus.fft_sink_eop, 0);
        check("rst_real", bus.fft_sink_real, 0);
        check("rst_imag", bus.fft_sink_imag, 0);
        check("rst_error", bus.fft_sink_error, 0);
        check("rst_inverse", bus.fft_inverse, 0);
        check("rst_fftpts", bus.fft_fftpts, N);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_drop_cnt", drop_cnt, 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        enable = 1'b0; sample_valid = 1'b0; inverse_req = 1'b0;
        bus.fft_sink_ready = 1'b1;
        ramp = '0;
        m_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_until(input int target);
        int n = 0;
        while (m_total < target && n < 4 * target + 50) begin
            sample_data = ramp;
            cycle(1);
            if (m_acc) ramp++;
            n++;
        end
        check("reach_idx", m_total, target);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit en, sv, rdy;
        logic [DW-1:0] d;
        bit e_sready, e_valid, e_sop, e_busy;
        logic [DW-1:0] e_data;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vt[7];

    initial begin
        int n_sop, n_eop, n_done, n_x, n_v, n_inv1;
        logic [DW-1:0] sop_d[$];
        logic [DW-1:0] eop_d[$];
        bit last_eop, seen;
        logic [DW-1:0] last_d;

        vt[0] = '{en:0, sv:1, rdy:1, d:5,  e_sready:0, e_valid:0, e_sop:0, e_busy:0, e_data:0,  e_drop:0};
        vt[1] = '{en:1, sv:1, rdy:1, d:6,  e_sready:0, e_valid:0, e_sop:0, e_busy:0, e_data:0,  e_drop:0};
        vt[2] = '{en:1, sv:1, rdy:1, d:7,  e_sready:1, e_valid:0, e_sop:0, e_busy:1, e_data:0,  e_drop:0};
        vt[3] = '{en:1, sv:1, rdy:0, d:8,  e_sready:0, e_valid:1, e_sop:1, e_busy:1, e_data:7,  e_drop:0};
        vt[4] = '{en:1, sv:0, rdy:1, d:9,  e_sready:1, e_valid:1, e_sop:1, e_busy:1, e_data:7,  e_drop:1};
        vt[5] = '{en:1, sv:1, rdy:1, d:10, e_sready:1, e_valid:0, e_sop:0, e_busy:1, e_data:0,  e_drop:1};
        vt[6] = '{en:1, sv:0, rdy:1, d:11, e_sready:1, e_valid:1, e_sop:0, e_busy:1, e_data:10, e_drop:1};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            enable = vt[i].en; sample_valid = vt[i].sv;
            bus.fft_sink_ready = vt[i].rdy; sample_data = vt[i].d;
            #1;
            check($sformatf("vec%0d_sready", i), sample_ready, vt[i].e_sready);
            check($sformatf("vec%0d_valid", i), bus.fft_sink_valid, vt[i].e_valid);
            check($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
            check($sformatf("vec%0d_drop", i), drop_cnt, vt[i].e_drop);
            if (vt[i].e_valid) begin
                check($sformatf("vec%0d_sop", i), bus.fft_sink_sop, vt[i].e_sop);
                check($sformatf("vec%0d_data", i), bus.fft_sink_real, vt[i].e_data);
            end
            @(posedge clk);
            m_step();
            @(negedge clk);
        end

        // 1: two back-to-back frames of a ramp at full throughput.
        do_reset();
        enable = 1; sample_valid = 1;
        n_sop = 0; n_eop = 0; n_done = 0;
        for (int i = 0; i < 1200 && m_total < 1024; i++) begin
            sample_data = ramp;
            cycle(1);
            if (m_acc) ramp++;
            if (x_now && x_sop) sop_d.push_back(x_data);
            if (x_now && x_eop) eop_d.push_back(x_data);
            if (done_now) n_done++;
        end
        sample_valid = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1);
            if (x_now && x_sop) sop_d.push_back(x_data);
            if (x_now && x_eop) eop_d.push_back(x_data);
            if (done_now) n_done++;
        end
        check("t1_sop_count", sop_d.size(), 2);
        check("t1_eop_count", eop_d.size(), 2);
        if (sop_d.size() == 2) begin
            check("t1_sop0_data", sop_d[0], 0);
            check("t1_sop1_data", sop_d[1], 512);
        end
        if (eop_d.size() == 2) begin
            check("t1_eop0_data", eop_d[0], 511);
            check("t1_eop1_data", eop_d[1], 1023);
        end
        check("t1_frame_done", n_done, 2);
        check("t1_drop_cnt", drop_cnt, 0);

        // 2: three cycles of back-pressure at idx 100.
        do_reset();
        enable = 1; sample_valid = 1;
        run_until(100);
        bus.fft_sink_ready = 0;
        for (int i = 0; i < 3; i++) begin
            sample_data = ramp;
            #1;
            check("t2_hold_data", bus.fft_sink_real, 99);
            check("t2_hold_sop", bus.fft_sink_sop, 0);
            check("t2_hold_eop", bus.fft_sink_eop, 0);
            check("t2_hold_valid", bus.fft_sink_valid, 1);
            check("t2_sample_ready", sample_ready, 0);
            #0;
            cycle(1);
        end
        check("t2_drop_cnt", drop_cnt, 3);
        check("t2_overrun", overrun, 1);
        bus.fft_sink_ready = 1;
        n_x = 99; seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            sample_data = ramp;
            cycle(1);
            if (m_acc) ramp++;
            if (x_now) begin
                n_x++;
                if (x_eop) begin
                    seen = 1;
                    check("t2_eop_at_512", n_x, 512);
                end
            end
        end
        check("t2_eop_seen", seen, 1);

        // 3: enable dropped at idx 200; the open frame is finished, then idle.
        do_reset();
        enable = 1; sample_valid = 1;
        run_until(200);
        enable = 0;
        n_x = 0; last_eop = 0; last_d = '0;
        for (int i = 0; i < 1000 && busy; i++) begin
            sample_data = ramp;
            cycle(1);
            if (m_acc) ramp++;
            if (x_now) begin n_x++; last_eop = x_eop; last_d = x_data; end
        end
        check("t3_idle", busy, 0);
        check("t3_beats_after_stop", n_x, 312 + 1);
        check("t3_last_eop", last_eop, 1);
        check("t3_last_data", last_d, 511);
        n_v = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1);
            if (bus.fft_sink_valid) n_v++;
        end
        check("t3_no_beats_idle", n_v, 0);
        check("t3_busy_idle", busy, 0);

        // 4: direction request toggled mid-frame applies from the next sop.
        do_reset();
        enable = 1; sample_valid = 1;
        run_until(300);
        inverse_req = 1;
        n_inv1 = 0; seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            sample_data = ramp;
            cycle(1);
            if (m_acc) ramp++;
            if (x_now && x_sop && x_data == 512) begin
                seen = 1;
                check("t4_inverse_frame1", x_inv, 1);
            end else if (x_now && x_inv) begin
                n_inv1++;
            end
        end
        check("t4_sop1_seen", seen, 1);
        check("t4_inverse_frame0", n_inv1, 0);

        // 5: asynchronous reset mid-frame, restart with a fresh sop.
        do_reset();
        enable = 1; sample_valid = 1;
        run_until(250);
        #2;
        reset_n = 0;
        m_reset();
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset_n = 1;
        ramp = 16'd1000;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample_data = ramp;
            cycle(1);
            if (m_acc) ramp++;
            if (x_now) begin
                seen = 1;
                check("t5_first_sop", x_sop, 1);
                check("t5_first_data", x_data, 1000);
            end
        end
        check("t5_beat_seen", seen, 1);

        // 6: long back-pressure saturates the drop counter.
        do_reset();
        enable = 1; sample_valid = 1;
        run_until(10);
        bus.fft_sink_ready = 0;
        for (int i = 0; i < 70000; i++) cycle(0);
        check("t6_drop_sat", drop_cnt, 16'hFFFF);
        check("t6_overrun", overrun, 1);
        for (int i = 0; i < 5; i++) cycle(1);
        check("t6_no_wrap", drop_cnt, 16'hFFFF);

        // Random traffic against the model.
        do_reset();
        enable = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) enable = ~enable;
            sample_valid = ($urandom_range(9) < 8);
            bus.fft_sink_ready = ($urandom_range(9) < 7);
            inverse_req = $urandom_range(1);
            sample_data = DW'($urandom);
            cycle(1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
